tick_timer: RTL and testbench
=============================

TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 Parameter WIDTH, default 16, width of LOAD and COUNT.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2, depth of the TICK_IN synchronizer.
REQ-003 CLK  input  1  system clock; all flops on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 TICK_IN  input  1  divided-clock level from upstream clock divider OUT_CLK; asynchronous to use, may be any duty cycle.
REQ-006 START  input  1  single-cycle command: load LOAD and run.
REQ-007 STOP  input  1  single-cycle command: abort run.
REQ-008 MODE  input  1  0 = one-shot, 1 = periodic; sampled at START.
REQ-009 LOAD  input  WIDTH  tick count to expiry.
REQ-010 COUNT  output  WIDTH  remaining ticks, registered.
REQ-011 BUSY  output  1  high while state is RUN.
REQ-012 DONE  output  1  one-CLK pulse on expiry.

Function
REQ-013 TICK_IN shall pass through SYNC_STAGES flops then a rising-edge detector producing a one-CLK internal pulse TICK.
REQ-014 TICK shall be high during the cycle ending at the (SYNC_STAGES+1)th rising CLK edge counted from the first edge that samples TICK_IN high; that edge applies the decrement.
REQ-015 States: IDLE, RUN; BUSY = (state == RUN).
REQ-016 IDLE + START, LOAD != 0 -> COUNT <= LOAD, latch MODE, go RUN.
REQ-017 IDLE + START, LOAD == 0 -> stay IDLE, COUNT <= 0, DONE pulses on the next edge.
REQ-018 RUN + TICK, COUNT > 1 -> COUNT <= COUNT - 1.
REQ-019 RUN + TICK, COUNT == 1, one-shot -> COUNT <= 0, DONE pulses, go IDLE.
REQ-020 RUN + TICK, COUNT == 1, periodic -> COUNT <= current LOAD, DONE pulses, stay RUN; if LOAD == 0, COUNT <= 0 and go IDLE.
REQ-021 RUN + STOP -> go IDLE, COUNT holds, no DONE.
REQ-022 RUN + START -> restart: COUNT <= LOAD, MODE re-latched, pending TICK discarded.
REQ-023 Priority: STOP over START over TICK when coincident.
REQ-024 TICK pulses in IDLE shall be ignored.
REQ-025 DONE shall be registered on the same edge that COUNT reaches its expiry value.
REQ-026 COUNT shall never underflow or wrap.

Reset
REQ-027 RST shall clear synchronizer flops, edge-detect flop, latched MODE, COUNT = 0, DONE = 0, state = IDLE (BUSY = 0).
REQ-028 RST mid-RUN shall abort with no DONE.
REQ-029 RST has priority over all commands.

Configuration
REQ-030 Macro TICK_TIMER_IRQ_EN: when defined, add input IRQ_CLR (1) and output IRQ (1).
REQ-031 IRQ shall be a sticky flag set on DONE and cleared by IRQ_CLR; set wins when coincident; reset value 0.
REQ-032 Without TICK_TIMER_IRQ_EN, neither port nor its logic shall exist.

Structure
REQ-033 Package tick_timer_pkg shall hold the state enum (IDLE, RUN) and the WIDTH and SYNC_STAGES defaults.
REQ-034 Sub-module tick_sync (synchronizer plus rising-edge detector, output TICK) shall be instantiated once.

Verification (SYNC_STAGES = 2; TICK_IN period 20 CLK unless noted)
REQ-035 One-shot, LOAD = 3, START -> COUNT 3, 2, 1, 0; single DONE pulse on the edge COUNT reaches 0; BUSY falls on that edge.
REQ-036 Periodic, LOAD = 2 -> DONE every 40 CLK; COUNT reloads to 2; BUSY stays high; STOP then -> IDLE with COUNT held, no further DONE.
REQ-037 Latency: TICK_IN rises just before edge k -> COUNT decrements exactly on edge k+2; TICK_IN held high 15 cycles -> single decrement.
REQ-038 Coincident events:
- STOP + START same cycle -> IDLE.
- START coincident with TICK in RUN -> COUNT = LOAD, no decrement.
- LOAD = 0 START -> DONE 1 cycle later, BUSY never high.
REQ-039 RST asserted in RUN at COUNT = 5 -> next edge COUNT = 0, BUSY = 0, DONE = 0; with TICK_TIMER_IRQ_EN, IRQ set by DONE persists until IRQ_CLR and is not cleared when IRQ_CLR coincides with DONE.

Source files
------------

// File: rtl/tick_timer_pkg.sv
// Shared types and defaults for the tick_timer block.
package tick_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH       = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/tick_timer_sync.sv
// tick_sync: brings the asynchronous TICK_IN level into the CLK domain and
// turns each rising edge into a single-cycle TICK pulse.
module tick_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic TICK_IN,
  output logic TICK
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // synchronizer chain plus the delayed copy used for edge detection
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], TICK_IN};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  // pulse is combinational so the edge after it applies the decrement
  always_comb begin
    TICK = sync[SYNC_STAGES-1] & ~prev;
  end

endmodule

// File: rtl/tick_timer.sv
// tick_timer: one-shot / periodic down-counter advanced by synchronized
// TICK_IN rising edges. Optional sticky IRQ under TICK_TIMER_IRQ_EN.
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TICK_IN,
  input  logic             START,
  input  logic             STOP,
  input  logic             MODE,
  input  logic [WIDTH-1:0] LOAD,
`ifdef TICK_TIMER_IRQ_EN
  input  logic             IRQ_CLR,
  output logic             IRQ,
`endif
  output logic [WIDTH-1:0] COUNT,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  logic             mode_q;
  logic             mode_next;
  logic             done_q;
  logic             done_next;
  logic             tick;

  tick_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tick_sync (
    .CLK    (CLK),
    .RST    (RST),
    .TICK_IN(TICK_IN),
    .TICK   (tick)
  );

  // state register: FSM state, remaining count, latched mode, done pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      count  <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      mode_q <= mode_next;
      done_q <= done_next;
    end
  end

  // next-state logic; STOP beats START beats TICK
  always_comb begin
    state_next = state;
    count_next = count;
    mode_next  = mode_q;
    done_next  = 1'b0;
    if (STOP) begin
      state_next = IDLE;
    end else if (START) begin
      if (LOAD != '0) begin
        count_next = LOAD;
        mode_next  = MODE;
        state_next = RUN;
      end else begin
        count_next = '0;
        done_next  = 1'b1;
        state_next = IDLE;
      end
    end else begin
      case (state)
        IDLE: begin
          state_next = IDLE;
        end
        RUN: begin
          if (!tick) begin
            state_next = RUN;
          end else if (count > ONE) begin
            count_next = count - ONE;
          end else if (count == ONE) begin
            done_next = 1'b1;
            if (mode_q && (LOAD != '0)) begin
              count_next = LOAD;
            end else begin
              count_next = '0;
              state_next = IDLE;
            end
          end else begin
            // zero count in RUN cannot arise; fall back to IDLE without wrapping
            count_next = '0;
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  // output decode from registered state
  always_comb begin
    COUNT = count;
    BUSY  = (state == RUN);
    DONE  = done_q;
  end

`ifdef TICK_TIMER_IRQ_EN
  logic irq_q;

  // sticky interrupt: set on expiry, set wins over a coincident clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      irq_q <= 1'b0;
    end else if (done_next) begin
      irq_q <= 1'b1;
    end else if (IRQ_CLR) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_q;
    end
  end

  // interrupt output
  always_comb begin
    IRQ = irq_q;
  end
`endif

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: hand-derived vector table, periodic
// and reset sequences, then randomized traffic against a behavioural model.
module tb_tick_timer;

  localparam int W    = 16;
  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tick_in = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] load = '0;
  logic         irq_clr = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
`ifdef TICK_TIMER_IRQ_EN
  logic         irq;
`endif

  tick_timer #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .CLK    (clk),
    .RST    (rst),
    .TICK_IN(tick_in),
    .START  (start),
    .STOP   (stop),
    .MODE   (mode),
    .LOAD   (load),
`ifdef TICK_TIMER_IRQ_EN
    .IRQ_CLR(irq_clr),
    .IRQ    (irq),
`endif
    .COUNT  (count),
    .BUSY   (busy),
    .DONE   (done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // behavioural reference: timer as an integer countdown plus a run flag
  bit hist[$];   // hist[k] = TICK_IN level sampled k+1 edges ago
  bit m_run;
  int m_count;
  bit m_mode;
  bit m_done;
  bit m_irq;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
  endtask

  function automatic void model_reset_hist();
    hist.delete();
    for (int i = 0; i <= SYNC; i++) hist.push_back(1'b0);
  endfunction

  // one rising edge of the reference model
  function automatic void model_edge();
    // a tick lands SYNC edges after the first edge that sees TICK_IN high
    bit t = hist[SYNC-1] && !hist[SYNC];
    if (rst) begin
      m_run = 0; m_count = 0; m_mode = 0; m_done = 0; m_irq = 0;
      model_reset_hist();
      return;
    end
    m_done = 0;
    if (stop) begin
      m_run = 0;
    end else if (start) begin
      if (load != 0) begin
        m_count = load; m_mode = mode; m_run = 1;
      end else begin
        m_count = 0; m_run = 0; m_done = 1;
      end
    end else if (m_run && t) begin
      if (m_count > 1) m_count = m_count - 1;
      else begin
        m_done = 1;
        if (m_mode && load != 0) m_count = load;
        else begin m_count = 0; m_run = 0; end
      end
    end
    if (m_done) m_irq = 1;
    else if (irq_clr) m_irq = 0;
    hist.push_front(tick_in);
    void'(hist.pop_back());
  endfunction

  task automatic cycle(input bit r, input bit s, input bit p, input bit m,
                       input logic [W-1:0] l, input bit t, input bit c);
    rst = r; start = s; stop = p; mode = m; load = l; tick_in = t; irq_clr = c;
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    chk("model_count", count, m_count);
    chk("model_busy", busy, m_run);
    chk("model_done", done, m_done);
`ifdef TICK_TIMER_IRQ_EN
    chk("model_irq", irq, m_irq);
`endif
  endtask

  typedef struct {
    bit r; bit s; bit p; bit m; int l; bit t;
    int e_count; bit e_busy; bit e_done;
  } vec_t;

  vec_t vt[$];

  initial begin
    int last_done;
    int n_done;
    model_reset_hist();
    m_run = 0; m_count = 0; m_mode = 0; m_done = 0; m_irq = 0;

    //          r  s  p  m  load tin  count busy done
    vt.push_back('{1, 0, 0, 0, 0, 0,   0, 0, 0});
    vt.push_back('{0, 1, 0, 0, 3, 0,   3, 1, 0});
    vt.push_back('{0, 0, 0, 0, 3, 1,   3, 1, 0});
    vt.push_back('{0, 0, 0, 0, 3, 1,   3, 1, 0});
    vt.push_back('{0, 0, 0, 0, 3, 0,   2, 1, 0});
    vt.push_back('{0, 0, 0, 0, 3, 0,   2, 1, 0});
    vt.push_back('{0, 0, 0, 0, 3, 1,   2, 1, 0});
    vt.push_back('{0, 0, 0, 0, 3, 0,   2, 1, 0});
    vt.push_back('{0, 0, 0, 0, 3, 0,   1, 1, 0});
    vt.push_back('{0, 0, 0, 0, 3, 1,   1, 1, 0});
    vt.push_back('{0, 0, 0, 0, 3, 0,   1, 1, 0});
    vt.push_back('{0, 0, 0, 0, 3, 0,   0, 0, 1});
    vt.push_back('{0, 0, 0, 0, 3, 0,   0, 0, 0});
    vt.push_back('{0, 1, 0, 0, 0, 0,   0, 0, 1});
    vt.push_back('{0, 0, 0, 0, 0, 0,   0, 0, 0});
    vt.push_back('{0, 1, 0, 1, 5, 0,   5, 1, 0});
    vt.push_back('{0, 1, 1, 1, 9, 0,   5, 0, 0});
    vt.push_back('{0, 1, 0, 0, 4, 0,   4, 1, 0});
    vt.push_back('{0, 0, 0, 0, 4, 1,   4, 1, 0});
    vt.push_back('{0, 0, 0, 0, 4, 0,   4, 1, 0});
    vt.push_back('{0, 1, 0, 0, 7, 0,   7, 1, 0});
    vt.push_back('{0, 0, 0, 0, 7, 0,   7, 1, 0});
    vt.push_back('{1, 0, 0, 0, 7, 0,   0, 0, 0});

    for (int i = 0; i < vt.size(); i++) begin
      cycle(vt[i].r, vt[i].s, vt[i].p, vt[i].m, W'(vt[i].l), vt[i].t, 1'b0);
      chk($sformatf("vec%0d_count", i), count, vt[i].e_count);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
      chk($sformatf("vec%0d_done", i), done, vt[i].e_done);
    end

    // periodic LOAD=2 with a 20-cycle TICK_IN: DONE every 40 cycles
    cycle(0, 1, 0, 1, 16'd2, 0, 0);
    last_done = -1;
    n_done = 0;
    for (int c = 1; c <= 200; c++) begin
      cycle(0, 0, 0, 1, 16'd2, ((c % 20) >= 10), 0);
      chk("periodic_busy", busy, 1);
      if (done) begin
        if (last_done >= 0) chk("periodic_interval", cyc - last_done, 40);
        last_done = cyc;
        n_done++;
      end
    end
    chk("periodic_done_seen", (n_done >= 4), 1);
    cycle(0, 0, 1, 1, 16'd2, 0, 0);
    n_done = 0;
    for (int c = 0; c < 80; c++) begin
      cycle(0, 0, 0, 1, 16'd2, ((c % 20) >= 10), 0);
      n_done += int'(done);
    end
    chk("after_stop_no_done", n_done, 0);
    chk("after_stop_busy", busy, 0);

    // reset in RUN at COUNT=5 aborts without DONE
    cycle(0, 1, 0, 0, 16'd5, 0, 0);
    chk("pre_reset_count", count, 5);
    cycle(1, 0, 0, 0, 16'd5, 0, 0);
    chk("reset_count", count, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

`ifdef TICK_TIMER_IRQ_EN
    // IRQ set wins over coincident clear, then persists until cleared
    cycle(0, 1, 0, 0, 16'd0, 0, 1);
    chk("irq_set_vs_clr", irq, 1);
    for (int c = 0; c < 5; c++) cycle(0, 0, 0, 0, 16'd0, 0, 0);
    chk("irq_sticky", irq, 1);
    cycle(0, 0, 0, 0, 16'd0, 0, 1);
    chk("irq_cleared", irq, 0);
`endif

    // randomized traffic against the model
    begin
      bit lvl = 0;
      for (int c = 0; c < 4000; c++) begin
        logic [W-1:0] l;
        if ($urandom_range(0, 3) == 0) lvl = ~lvl;
        l = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 65535))
                                        : W'($urandom_range(0, 4));
        cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 29) == 0),
              ($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), l, lvl,
              ($urandom_range(0, 15) == 0));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
